// File: rtl/fixed_point_requantizer_if.sv
// Stream bundle for the requantizer: result-triple input side and serial Q(4,12) word output side.
interface fixed_point_requantizer_if;
    logic                in_valid;
    logic                in_ready;
    logic signed [17:0]  in_sum;
    logic signed [17:0]  in_diff;
    logic signed [34:0]  in_product;
    logic                out_valid;
    logic                out_ready;
    logic signed [15:0]  out_data;
    logic [1:0]          out_sel;
    logic                out_last;
    logic                out_sat;
    logic [15:0]         sat_count;

    modport slave (
        input  in_valid, in_sum, in_diff, in_product, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last, out_sat, sat_count
    );

    modport master (
        output in_valid, in_sum, in_diff, in_product, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last, out_sat, sat_count
    );
endinterface

// File: rtl/fixed_point_requantizer.sv
// Rounds/saturates sum, diff and product results to Q(4,12), buffers triples in a FIFO
// and streams them out as three words per triple, counting clipped words.
module fixed_point_requantizer #(
    parameter int DEPTH    = 4,
    parameter int IN_FRAC  = 14,
    parameter int OUT_FRAC = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    fixed_point_requantizer_if.slave   rq
);
    localparam int S  = IN_FRAC - OUT_FRAC;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic signed [35:0] HALF = 36'sd1 <<< (S - 1);

    typedef struct packed {
        logic               sat;
        logic signed [15:0] word;
    } rq_word_t;

    // Round half toward +inf, then clip to the 16-bit signed range.
    function automatic rq_word_t requant(input logic signed [34:0] x);
        logic signed [35:0] ext;
        logic signed [35:0] shd;
        rq_word_t           r;
        ext = $signed({x[34], x}) + HALF;
        shd = ext >>> S;
        if (shd > 36'sd32767) begin
            r.sat  = 1'b1;
            r.word = 16'sh7FFF;
        end else if (shd < -36'sd32768) begin
            r.sat  = 1'b1;
            r.word = 16'sh8000;
        end else begin
            r.sat  = 1'b0;
            r.word = shd[15:0];
        end
        return r;
    endfunction

    rq_word_t        mem_q [DEPTH][3];
    rq_word_t        conv  [3];
    rq_word_t        head;

    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]      beat_q, beat_d;
    logic [15:0]     sat_count_q, sat_count_d;

    logic            push, fire, pop;
    logic [1:0]      sat_add;
    logic [16:0]     sat_sum;

    always_comb begin
        conv[0] = requant(35'(rq.in_sum));
        conv[1] = requant(35'(rq.in_diff));
        conv[2] = requant(rq.in_product);
    end

    assign rq.in_ready  = !rst && (count_q < (AW+1)'(DEPTH));
    assign rq.out_valid = (count_q != '0);

    assign push = rq.in_valid && rq.in_ready;
    assign fire = rq.out_valid && rq.out_ready;
    assign pop  = fire && (beat_q == 2'd2);

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_d      = beat_q;
        sat_count_d = sat_count_q;
        sat_add     = {1'b0, conv[0].sat} + {1'b0, conv[1].sat} + {1'b0, conv[2].sat};
        sat_sum     = {1'b0, sat_count_q} + {15'd0, sat_add};

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
        if (fire) begin
            beat_d = pop ? 2'd0 : beat_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beat_q      <= 2'd0;
            sat_count_q <= 16'd0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_q      <= beat_d;
            sat_count_q <= sat_count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q][0] <= conv[0];
            mem_q[wr_ptr_q][1] <= conv[1];
            mem_q[wr_ptr_q][2] <= conv[2];
        end
    end

    assign head         = mem_q[rd_ptr_q][beat_q];
    assign rq.out_data  = rq.out_valid ? head.word : 16'sd0;
    assign rq.out_sat   = rq.out_valid ? head.sat  : 1'b0;
    assign rq.out_sel   = rq.out_valid ? beat_q    : 2'd0;
    assign rq.out_last  = rq.out_valid && (beat_q == 2'd2);
    assign rq.sat_count = sat_count_q;

endmodule

// File: tb/tb_fixed_point_requantizer.sv
// Directed bench for fixed_point_requantizer: rounding, saturation, back-pressure,
// simultaneous push/pop, mid-stream reset and sat_count clamping.
module tb_fixed_point_requantizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    fixed_point_requantizer_if rq ();

    fixed_point_requantizer #(.DEPTH(4), .IN_FRAC(14), .OUT_FRAC(12)) dut (
        .clk (clk),
        .rst (rst),
        .rq  (rq.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one triple and waits (bounded) until it is accepted.
    task automatic push(input int s, input int d, input longint p);
        int wait_cyc;
        rq.in_sum     = 18'(s);
        rq.in_diff    = 18'(d);
        rq.in_product = 35'(p);
        rq.in_valid   = 1'b1;
        #1;
        wait_cyc = 0;
        while (!rq.in_ready && wait_cyc < 50) begin
            step();
            wait_cyc++;
        end
        vec_cnt++;
        if (!rq.in_ready) begin
            err_cnt++;
            $display("FAIL push_timeout: in_ready=%0b required 1", rq.in_ready);
        end
        step();
        rq.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vec_cnt++; if (rq.in_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_in_ready: got %0b want 0", rq.in_ready); end
        vec_cnt++; if (rq.out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid: got %0b want 0", rq.out_valid); end
        vec_cnt++; if (rq.out_data !== 16'sd0) begin err_cnt++; $display("FAIL rst_out_data: got %0d want 0", rq.out_data); end
        vec_cnt++; if ({rq.out_sel, rq.out_last, rq.out_sat} !== 4'b0) begin err_cnt++; $display("FAIL rst_out_ctrl: got %b want 0000", {rq.out_sel, rq.out_last, rq.out_sat}); end
        vec_cnt++; if (rq.sat_count !== 16'd0) begin err_cnt++; $display("FAIL rst_sat_count: got %0d want 0", rq.sat_count); end
        rst = 1'b0;
        #1;
        vec_cnt++; if (rq.in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_release_in_ready: got %0b want 1", rq.in_ready); end
    endtask

    task automatic test_rounding();
        int exp_d [3] = '{1, -1, 1};
        rq.out_ready = 1'b0;
        push(2, -3, 4);
        for (int i = 0; i < 3; i++) begin
            vec_cnt++; if (rq.out_valid !== 1'b1) begin err_cnt++; $display("FAIL round_valid[%0d]: got %0b want 1", i, rq.out_valid); end
            vec_cnt++; if (rq.out_data !== 16'(exp_d[i])) begin err_cnt++; $display("FAIL round_data[%0d]: got %0d want %0d", i, rq.out_data, exp_d[i]); end
            vec_cnt++; if (rq.out_sel !== 2'(i)) begin err_cnt++; $display("FAIL round_sel[%0d]: got %0d want %0d", i, rq.out_sel, i); end
            vec_cnt++; if (rq.out_last !== (i == 2)) begin err_cnt++; $display("FAIL round_last[%0d]: got %0b want %0b", i, rq.out_last, (i == 2)); end
            vec_cnt++; if (rq.out_sat !== 1'b0) begin err_cnt++; $display("FAIL round_sat[%0d]: got %0b want 0", i, rq.out_sat); end
            rq.out_ready = 1'b1;
            step();
            rq.out_ready = 1'b0;
        end
        vec_cnt++; if (rq.out_valid !== 1'b0) begin err_cnt++; $display("FAIL round_empty: got %0b want 0", rq.out_valid); end
        vec_cnt++; if (rq.sat_count !== 16'd0) begin err_cnt++; $display("FAIL round_sat_count: got %0d want 0", rq.sat_count); end
    endtask

    task automatic test_saturation();
        int   exp_d [3] = '{32767, -32768, 32767};
        logic exp_s [3] = '{1'b1, 1'b0, 1'b1};
        rq.out_ready = 1'b0;
        push(131071, -131072, 200000);
        vec_cnt++; if (rq.sat_count !== 16'd2) begin err_cnt++; $display("FAIL sat_count: got %0d want 2", rq.sat_count); end
        for (int i = 0; i < 3; i++) begin
            vec_cnt++; if (rq.out_data !== 16'(exp_d[i])) begin err_cnt++; $display("FAIL sat_data[%0d]: got %0d want %0d", i, rq.out_data, exp_d[i]); end
            vec_cnt++; if (rq.out_sat !== exp_s[i]) begin err_cnt++; $display("FAIL sat_flag[%0d]: got %0b want %0b", i, rq.out_sat, exp_s[i]); end
            rq.out_ready = 1'b1;
            step();
            rq.out_ready = 1'b0;
        end
        vec_cnt++; if (rq.out_valid !== 1'b0) begin err_cnt++; $display("FAIL sat_empty: got %0b want 0", rq.out_valid); end
    endtask

    // Triple k carries words 3k+1, 3k+2, 3k+3 exactly (inputs are 4x the word value).
    task automatic test_backpressure();
        rq.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(4*(3*k+1), 4*(3*k+2), 4*(3*k+3));
        vec_cnt++; if (rq.in_ready !== 1'b0) begin err_cnt++; $display("FAIL full_in_ready: got %0b want 0", rq.in_ready); end
        rq.in_sum     = 18'(4*13);
        rq.in_diff    = 18'(4*14);
        rq.in_product = 35'(4*15);
        rq.in_valid   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vec_cnt++; if (rq.in_ready !== 1'b0) begin err_cnt++; $display("FAIL full_hold_ready[%0d]: got %0b want 0", c, rq.in_ready); end
            vec_cnt++; if (rq.out_data !== 16'sd1 || rq.out_sel !== 2'd0) begin err_cnt++; $display("FAIL full_hold_data[%0d]: got %0d/%0d want 1/0", c, rq.out_data, rq.out_sel); end
        end
        rq.out_ready = 1'b1;
        for (int j = 0; j < 15; j++) begin
            vec_cnt++; if (rq.out_valid !== 1'b1 || rq.out_data !== 16'(j+1)) begin err_cnt++; $display("FAIL drain_data[%0d]: got v=%0b d=%0d want v=1 d=%0d", j, rq.out_valid, rq.out_data, j+1); end
            vec_cnt++; if (rq.out_sel !== 2'(j % 3)) begin err_cnt++; $display("FAIL drain_sel[%0d]: got %0d want %0d", j, rq.out_sel, j % 3); end
            if (j == 2) begin
                vec_cnt++; if (rq.in_ready !== 1'b0) begin err_cnt++; $display("FAIL drain_ready_early: got %0b want 0", rq.in_ready); end
            end
            if (j == 3) begin
                vec_cnt++; if (rq.in_ready !== 1'b1) begin err_cnt++; $display("FAIL drain_ready_rise: got %0b want 1", rq.in_ready); end
            end
            step();
            if (j == 3) rq.in_valid = 1'b0;
        end
        vec_cnt++; if (rq.out_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_empty: got %0b want 0", rq.out_valid); end
        rq.out_ready = 1'b0;
    endtask

    task automatic test_push_pop();
        int exp_d [3] = '{31, 32, 33};
        rq.out_ready = 1'b0;
        push(84, 88, 92);
        rq.out_ready = 1'b1;
        step();
        step();
        vec_cnt++; if (rq.out_sel !== 2'd2 || rq.out_last !== 1'b1 || rq.out_data !== 16'sd23) begin err_cnt++; $display("FAIL pp_head_product: got sel=%0d last=%0b d=%0d want 2/1/23", rq.out_sel, rq.out_last, rq.out_data); end
        rq.in_sum     = 18'(124);
        rq.in_diff    = 18'(128);
        rq.in_product = 35'(132);
        rq.in_valid   = 1'b1;
        #1;
        vec_cnt++; if (rq.in_ready !== 1'b1) begin err_cnt++; $display("FAIL pp_in_ready: got %0b want 1", rq.in_ready); end
        step();
        rq.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vec_cnt++; if (rq.out_valid !== 1'b1 || rq.out_data !== 16'(exp_d[i]) || rq.out_sel !== 2'(i)) begin err_cnt++; $display("FAIL pp_next[%0d]: got v=%0b d=%0d sel=%0d want 1/%0d/%0d", i, rq.out_valid, rq.out_data, rq.out_sel, exp_d[i], i); end
            step();
        end
        vec_cnt++; if (rq.out_valid !== 1'b0) begin err_cnt++; $display("FAIL pp_count_one: got out_valid=%0b want 0", rq.out_valid); end
        rq.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        rq.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) push(131071, 4*(k+1), 200000);
        rq.out_ready = 1'b1;
        step();
        rq.out_ready = 1'b0;
        vec_cnt++; if (rq.out_sel !== 2'd1) begin err_cnt++; $display("FAIL mid_beat1: got sel=%0d want 1", rq.out_sel); end
        vec_cnt++; if (rq.sat_count === 16'd0) begin err_cnt++; $display("FAIL mid_sat_nonzero: got %0d want nonzero", rq.sat_count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        vec_cnt++; if (rq.out_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_out_valid: got %0b want 0", rq.out_valid); end
        vec_cnt++; if (rq.sat_count !== 16'd0) begin err_cnt++; $display("FAIL mid_sat_count: got %0d want 0", rq.sat_count); end
        push(28, 32, 36);
        vec_cnt++; if (rq.out_sel !== 2'd0 || rq.out_data !== 16'sd7) begin err_cnt++; $display("FAIL mid_fresh: got sel=%0d d=%0d want 0/7", rq.out_sel, rq.out_data); end
        rq.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        vec_cnt++; if (rq.out_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_drain: got %0b want 0", rq.out_valid); end
        rq.out_ready = 1'b0;
    endtask

    task automatic test_sat_clamp();
        int accepted;
        int cyc;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rq.in_sum     = 18'(131071);
        rq.in_diff    = 18'(131071);
        rq.in_product = 35'(200000);
        rq.in_valid   = 1'b1;
        rq.out_ready  = 1'b1;
        #1;
        accepted = 0;
        cyc      = 0;
        while (accepted < 21846 && cyc < 80000) begin
            if (rq.in_ready) accepted++;
            step();
            cyc++;
            if (accepted == 100) begin
                vec_cnt++; if (rq.sat_count !== 16'd300) begin err_cnt++; $display("FAIL clamp_partial: got %0d want 300", rq.sat_count); end
                accepted++;
                if (rq.in_ready) rq.in_valid = 1'b1;
                accepted--;
            end
        end
        rq.in_valid = 1'b0;
        vec_cnt++; if (accepted != 21846) begin err_cnt++; $display("FAIL clamp_timeout: got %0d accepted want 21846", accepted); end
        vec_cnt++; if (rq.sat_count !== 16'hFFFF) begin err_cnt++; $display("FAIL clamp_value: got %0h want ffff", rq.sat_count); end
        push(131071, 131071, 200000);
        vec_cnt++; if (rq.sat_count !== 16'hFFFF) begin err_cnt++; $display("FAIL clamp_hold: got %0h want ffff", rq.sat_count); end
        cyc = 0;
        while (rq.out_valid && cyc < 100) begin
            step();
            cyc++;
        end
        vec_cnt++; if (rq.out_valid !== 1'b0) begin err_cnt++; $display("FAIL clamp_drain: got %0b want 0", rq.out_valid); end
        rq.out_ready = 1'b0;
    endtask

    initial begin
        rq.in_valid   = 1'b0;
        rq.in_sum     = '0;
        rq.in_diff    = '0;
        rq.in_product = '0;
        rq.out_ready  = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_sat_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
